bank_cmd_arbiter: RTL
=====================

# bank_cmd_arbiter

Per-bank command arbiter in front of the DDR command issue stage. Each bank FSM presents one pending command (ACT/RD/WR/PRE). The arbiter filters requests against each bank's timing status from its tP_counter instance (tP_ba_counter==0, tRAS_counter==0) and against global inter-bank spacing (tRRD, tCCD). It then grants one eligible bank round-robin into a single-entry registered output, handed off to the issue stage with a valid/ready handshake.

## Interface
- NUM_BANK, 8, number of banks/requesters (power of two, ≥2)
- BA_W, 3, log2(NUM_BANK)
- CYCLE_TRRD, 4, ACT-to-ACT (any bank) spacing in clk cycles, ≥2
- CYCLE_TCCD, 4, RD/WR-to-RD/WR (any bank) spacing in clk cycles, ≥2
- clk  input  1  sole clock, all state on rising edge
- rst_n  input  1  asynchronous, active-low reset
- req_valid  input  NUM_BANK  bank b has a pending command
- req_cmd  input  2*NUM_BANK  bits [2b+1:2b] = command of bank b: 00 ACT, 01 RD, 10 WR, 11 PRE
- tp_zero  input  NUM_BANK  bank b tP_ba_counter==0 (tRCD/tRTP/tWR/tRP satisfied)
- tras_zero  input  NUM_BANK  bank b tRAS_counter==0
- req_ready  output  NUM_BANK  one-hot grant pulse; bank b's command captured this cycle
- issue_valid  output  1  issue register holds a command
- issue_ready  input  1  issue stage accepts the command
- issue_bank  output  BA_W  bank of held command
- issue_cmd  output  2  command code of held command

## Operation
- Bank b eligible iff all of:
  - req_valid[b] and tp_zero[b];
  - if PRE: tras_zero[b];
  - if ACT: trrd_cnt==0;
  - if RD/WR: tccd_cnt==0.
- Grant only when issue_valid==0. One command in flight; no grant in the handshake cycle.
- Round-robin: search eligible banks starting at rr_ptr, ascending, wrapping NUM_BANK-1→0. First hit wins.
- On grant to bank b:
  - req_ready[b]=1 for that cycle (combinational, all other bits 0);
  - next edge: issue_valid←1, issue_bank←b, issue_cmd←req_cmd[b], rr_ptr←(b+1) mod NUM_BANK.
- Requester must drop or replace its request the cycle after req_ready. Arbiter does not track it.
- Hold: while issue_valid && !issue_ready, issue_bank/issue_cmd stable; req_ready all 0.
- Handshake (issue_valid && issue_ready): issue_valid←0 next edge.
  - ACT: trrd_cnt←CYCLE_TRRD-2.
  - RD/WR: tccd_cnt←CYCLE_TCCD-2.
  - Otherwise each counter decrements and saturates at 0.
- Counters are BA_W-independent, width ceil(log2(max(CYCLE_*))+1). No underflow: decrement only when nonzero.
- No eligible bank: no grant, rr_ptr unchanged.
- rst_n low (asynchronous): issue_valid=0, issue_bank=0, issue_cmd=0, rr_ptr=0, trrd_cnt=0, tccd_cnt=0. req_ready forced 0 while rst_n low.
- Reset mid-hold: the held command is dropped. The requester already saw req_ready and must not re-present it.

## Timing
- Grant-to-issue_valid latency: 1 cycle.
- Minimum issue spacing: 2 cycles (grant cycle, handshake cycle).
- ACT accepted at cycle t → next ACT accepted no earlier than t+CYCLE_TRRD. RD/WR likewise with CYCLE_TCCD.
- tp_zero/tras_zero are sampled in the grant cycle only. They are not rechecked during hold.
- Same-bank follow-up is gated solely by that bank's tP_counter via tp_zero.

## Test plan
- Reset, then req_valid=8'h01, cmd ACT, tp_zero all 1, issue_ready=1 → req_ready=8'h01 at cycle 1; issue_valid=1, bank 0, cmd 00 at cycle 2; rr_ptr=1.
- All 8 banks request RD continuously, issue_ready=1, CYCLE_TCCD=4 → grants in order 0,1,…,7,0 with accepts exactly 4 cycles apart.
- Banks 2 and 5 request ACT simultaneously, rr_ptr=3 → bank 5 granted first. Bank 2 granted after trrd_cnt reaches 0; accept-to-accept = 4 cycles.
- Bank 3 requests PRE with tp_zero=1, tras_zero=0 for 6 cycles → no grant. tras_zero→1 at cycle 7 → req_ready[3] at cycle 7.
- Grant bank 1 WR, hold issue_ready=0 for 5 cycles while bank 4 requests → outputs stable, req_ready=0. issue_ready=1 → accept; bank 4 granted the next cycle (if tCCD satisfied or cmd ACT/PRE).
- Pull rst_n low mid-hold → issue_valid, counters, rr_ptr clear immediately without a clock edge. After release, first grant searches from bank 0.

Source files
------------

// File: rtl/bank_cmd_arbiter.sv
// bank_cmd_arbiter: round-robin DDR bank command arbiter with tRRD/tCCD spacing and a registered valid/ready issue slot
module bank_cmd_arbiter #(
  parameter int NUM_BANK = 8,
  parameter int BA_W = 3,
  parameter int CYCLE_TRRD = 4,
  parameter int CYCLE_TCCD = 4
) (
  input  logic                  clk,
  input  logic                  rst_n,
  input  logic [NUM_BANK-1:0]   req_valid,
  input  logic [2*NUM_BANK-1:0] req_cmd,
  input  logic [NUM_BANK-1:0]   tp_zero,
  input  logic [NUM_BANK-1:0]   tras_zero,
  output logic [NUM_BANK-1:0]   req_ready,
  output logic                  issue_valid,
  input  logic                  issue_ready,
  output logic [BA_W-1:0]       issue_bank,
  output logic [1:0]            issue_cmd
);
  localparam int CW = $clog2(CYCLE_TRRD > CYCLE_TCCD ? CYCLE_TRRD : CYCLE_TCCD) + 1;
  logic [CW-1:0] trrd_cnt, tccd_cnt;
  logic [BA_W-1:0] rr_ptr, gnt_bank, idx;
  logic [NUM_BANK-1:0] elig;
  logic [1:0] cmd;
  logic hit, gnt, hs;
  always_comb begin
    elig = '0;
    cmd = '0;
    for (int b = 0; b < NUM_BANK; b++) begin
      cmd = req_cmd[2*b+:2];
      elig[b] = req_valid[b] & tp_zero[b] &
                (cmd == 2'b11 ? tras_zero[b] : cmd == 2'b00 ? trrd_cnt == '0 : tccd_cnt == '0);
    end
  end
  // Scanning downward lets the lowest offset from rr_ptr overwrite, so the first ascending hit wins.
  always_comb begin
    hit = 1'b0;
    gnt_bank = '0;
    idx = '0;
    for (int i = NUM_BANK - 1; i >= 0; i--) begin
      idx = rr_ptr + BA_W'(i);
      if (elig[idx]) begin
        hit = 1'b1;
        gnt_bank = idx;
      end
    end
  end
  assign gnt = hit & ~issue_valid & rst_n;
  assign hs = issue_valid & issue_ready;
  assign req_ready = gnt ? {{(NUM_BANK-1){1'b0}}, 1'b1} << gnt_bank : '0;
  always_ff @(posedge clk or negedge rst_n)
    if (!rst_n) begin
      issue_valid <= 1'b0;
      issue_bank <= '0;
      issue_cmd <= '0;
      rr_ptr <= '0;
      trrd_cnt <= '0;
      tccd_cnt <= '0;
    end else begin
      if (gnt) begin
        issue_valid <= 1'b1;
        issue_bank <= gnt_bank;
        issue_cmd <= req_cmd[{gnt_bank, 1'b0}+:2];
        rr_ptr <= gnt_bank + BA_W'(1);
      end else if (hs)
        issue_valid <= 1'b0;
      trrd_cnt <= hs && issue_cmd == 2'b00 ? CW'(CYCLE_TRRD - 2) : trrd_cnt - CW'(trrd_cnt != '0);
      tccd_cnt <= hs && (issue_cmd == 2'b01 || issue_cmd == 2'b10) ? CW'(CYCLE_TCCD - 2)
                                                                  : tccd_cnt - CW'(tccd_cnt != '0);
    end
endmodule
